ofifo_collector: RTL
====================

Name: ofifo_collector

Overview:
- Output FIFO stage directly downstream of the MAC array. It captures per-column psum writes into COL independent column FIFOs and releases complete rows (one word from every column) to the SFP/readout path.
- Returns the ofifo_wr and ofifo_full status bits consumed by the controller.
- Absorbs column skew: a row is readable only once every column has produced its word.

Parameters:
- COL, 8, number of array columns / column FIFOs
- BW, 16, psum width per column (bits)
- DEPTH, 64, entries per column FIFO; power of two, ≥2
- PTR_W, $clog2(DEPTH)+1, pointer width including wrap bit (derived, not overridden)

Ports:
- clk  in  1  clock; all state on rising edge
- reset  in  1  asynchronous, active-high reset
- in  in  COL*BW  psum data; column c occupies bits [c*BW +: BW]
- wr  in  COL  per-column write strobe
- rd  in  1  row read request from downstream
- out  out  COL*BW  registered row data
- out_valid  out  1  pulse: out updated this cycle
- ofifo_wr  out  1  registered: at least one column write accepted last cycle
- ofifo_full  out  1  any column FIFO full
- o_ready  out  1  no column FIFO full (~ofifo_full)
- o_valid  out  1  every column FIFO non-empty (row available)
- row_count  out  PTR_W  min occupancy across columns (complete rows held)
- ovf_err  out  1  sticky: write to a full column dropped
- udf_err  out  1  sticky: rd while o_valid low

Behaviour:
- Reset (async assert, sync deassert release):
  - All pointers = 0; out = 0; out_valid, ofifo_wr, ovf_err, udf_err = 0.
  - Resulting outputs: ofifo_full = 0, o_ready = 1, o_valid = 0, row_count = 0.
  - Reset mid-operation discards all stored data immediately.
- Column FIFO state:
  - Each column has wptr and rptr of width PTR_W.
  - empty: wptr == rptr.
  - full: low bits equal and MSB differs.
  - occupancy = wptr − rptr, modulo 2^PTR_W.
- Read:
  - rd_eff = rd & o_valid.
  - On rd_eff, every column's rptr advances by 1 and out <= head of every column. out_valid = 1 the following cycle, i.e. 1-cycle latency.
  - If rd is high while o_valid is low: no pointer movement, out holds its value, out_valid = 0, udf_err set.
- Write:
  - Column c accepts its write when wr[c] & (~full[c] | rd_eff).
  - Write to a full column coincident with rd_eff is legal: the head is freed the same edge and occupancy stays DEPTH.
  - Write to a full column without rd_eff is dropped, pointers are unchanged, and ovf_err is set.
  - Columns write independently; skew between columns is permitted.
- Status timing:
  - ofifo_full, o_ready, o_valid and row_count are combinational from pointers, so they reflect state after the last edge.
  - ofifo_wr is registered: ofifo_wr(t+1) = OR over c of write-accepted[c](t).
- Wrap-around: pointers wrap naturally modulo 2^PTR_W. Data RAM is indexed by ptr[PTR_W-2:0].
- Sticky errors clear only on reset.
- No combinational path from rd to out; o_valid does not depend on rd.

Decomposition:
- Shared package ofifo_pkg: BW/COL defaults, a psum_t typedef, and a ptr_w(DEPTH) function.
- Sub-module fifo_col (one column):
  - Ports: clk, reset, wr, rd, in[BW], out[BW], full, empty, count[PTR_W].
  - Contents: register-array storage and pointers.
- ofifo_collector:
  - Instantiates COL × fifo_col via generate.
  - Performs the rd_eff/accept gating, the min-occupancy reduction, the output register and the error flags.

Test Plan:
1. Reset mid-fill: write 5 rows into all columns, assert reset for 1 cycle → o_valid = 0, row_count = 0, ofifo_full = 0, out = 0, no out_valid afterward.
2. Skewed columns: write col0..col6 with values 0x0100+c, col7 held off for 3 cycles → o_valid = 0 until col7 is written. The next cycle o_valid = 1 and row_count = 1; rd then gives out_valid with out[c] = 0x0100+c.
3. Fill to full: 64 writes to all columns with value = index → ofifo_full = 1 and o_ready = 0 after the 64th edge. A 65th write with no rd is dropped and sets ovf_err. Draining 64 rows returns 0..63 in order.
4. Full plus simultaneous read/write: full FIFO, wr = 0xFF with data 0xAAAA and rd = 1 the same cycle → accepted, row_count stays 64, no ovf_err. The row 0xAAAA emerges on the 64th subsequent read.
5. Underflow and ofifo_wr: rd = 1 while empty → udf_err = 1, out_valid = 0. Then a single wr[3] pulse → ofifo_wr = 1 exactly one cycle later, 0 after.
6. Wrap: 200 interleaved single-row write/read pairs → data order preserved across pointer wrap; row_count never exceeds 1.

Source files
------------

// File: rtl/ofifo_pkg.sv
// Shared defaults and helpers for the MAC-array output FIFO stage.
package ofifo_pkg;
    localparam int COL_DEF = 8;
    localparam int BW_DEF  = 16;

    typedef logic [BW_DEF-1:0] psum_t;

    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction
endpackage

// File: rtl/fifo_col.sv
// Single column FIFO: register-array storage, head visible combinationally.
// Caller gates wr/rd; a write while full is only issued together with a read.
module fifo_col
    import ofifo_pkg::*;
#(
    parameter  int BW    = BW_DEF,
    parameter  int DEPTH = 64,
    localparam int PTR_W = ptr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr,
    input  logic             rd,
    input  logic [BW-1:0]    in,
    output logic [BW-1:0]    out,
    output logic             full,
    output logic             empty,
    output logic [PTR_W-1:0] count
);
    logic [BW-1:0]    mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (wr) wptr_d = wptr_q + 1'b1;
        if (rd) rptr_d = rptr_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage needs no reset: pointers alone define valid contents.
    always_ff @(posedge clk) begin
        if (wr) mem_q[wptr_q[PTR_W-2:0]] <= in;
    end

    assign out   = mem_q[rptr_q[PTR_W-2:0]];
    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[PTR_W-1] != rptr_q[PTR_W-1]) &&
                   (wptr_q[PTR_W-2:0] == rptr_q[PTR_W-2:0]);
    assign count = wptr_q - rptr_q;
endmodule

// File: rtl/ofifo_collector.sv
// Collects skewed per-column psums and releases whole rows; out is registered, 1-cycle read latency.
// Writes to a full column are dropped (ovf_err) unless a row read frees the head the same edge.
module ofifo_collector
    import ofifo_pkg::*;
#(
    parameter  int COL   = COL_DEF,
    parameter  int BW    = BW_DEF,
    parameter  int DEPTH = 64,
    localparam int PTR_W = ptr_w(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [COL*BW-1:0] in,
    input  logic [COL-1:0]    wr,
    input  logic              rd,
    output logic [COL*BW-1:0] out,
    output logic              out_valid,
    output logic              ofifo_wr,
    output logic              ofifo_full,
    output logic              o_ready,
    output logic              o_valid,
    output logic [PTR_W-1:0]  row_count,
    output logic              ovf_err,
    output logic              udf_err
);
    logic [COL-1:0]    full, empty, accept;
    logic [PTR_W-1:0]  count [COL];
    logic [COL*BW-1:0] head;
    logic              rd_eff;

    logic [COL*BW-1:0] out_q, out_d;
    logic              out_valid_q, out_valid_d;
    logic              ofifo_wr_q, ofifo_wr_d;
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;

    for (genvar c = 0; c < COL; c++) begin : g_col
        fifo_col #(.BW(BW), .DEPTH(DEPTH)) u_col (
            .clk   (clk),
            .reset (reset),
            .wr    (accept[c]),
            .rd    (rd_eff),
            .in    (in[c*BW +: BW]),
            .out   (head[c*BW +: BW]),
            .full  (full[c]),
            .empty (empty[c]),
            .count (count[c])
        );
    end

    assign o_valid    = ~|empty;
    assign ofifo_full = |full;
    assign o_ready    = ~ofifo_full;
    assign rd_eff     = rd & o_valid;
    assign accept     = wr & (~full | {COL{rd_eff}});

    // Complete rows held = the least-filled column.
    always_comb begin
        row_count = count[0];
        for (int c = 1; c < COL; c++) begin
            if (count[c] < row_count) row_count = count[c];
        end
    end

    always_comb begin
        out_d       = out_q;
        out_valid_d = rd_eff;
        ofifo_wr_d  = |accept;
        ovf_d       = ovf_q | (|(wr & ~accept));
        udf_d       = udf_q | (rd & ~o_valid);
        if (rd_eff) out_d = head;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
            ofifo_wr_q  <= 1'b0;
            ovf_q       <= 1'b0;
            udf_q       <= 1'b0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            ofifo_wr_q  <= ofifo_wr_d;
            ovf_q       <= ovf_d;
            udf_q       <= udf_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign ofifo_wr  = ofifo_wr_q;
    assign ovf_err   = ovf_q;
    assign udf_err   = udf_q;
endmodule
